// File: rtl/conv_pkg.sv
// conv_pkg: shared geometry, widths, state type and index-width helper for the conv result path
package conv_pkg;
  localparam int IMG_W = 6;
  localparam int IMG_H = 6;
  localparam int K = 3;
  localparam int MAP_W = IMG_W - K + 1;
  localparam int MAP_H = IMG_H - K + 1;
  localparam int OUT_W = 16;
  localparam int PIX_W = 8;
  typedef enum logic {FILL, DRAIN} state_t;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/pix_clamp.sv
// pix_clamp: signed IN_W result to 8-bit pixel, saturating when CLAMP_EN else wrapping
// value: two's complement input; pix: 8-bit pixel; sat: value was outside [0,255] (CLAMP_EN only)
module pix_clamp #(
  parameter int IN_W = 16,
  parameter int CLAMP_EN = 1
) (
  input  logic [IN_W-1:0] value,
  output logic [7:0]      pix,
  output logic            sat
);
  logic neg, big;
  assign neg = value[IN_W-1];
  assign big = !neg && |value[IN_W-2:8];
  assign sat = (CLAMP_EN != 0) && (neg || big);
  assign pix = !sat ? value[7:0] : neg ? 8'd0 : 8'd255;
endmodule

// File: rtl/conv_result_collector.sv
// conv_result_collector: clamp and buffer one conv result map, then stream it out in raster order
// sys_clk/sys_rst: clock and synchronous active-high reset
// in_valid/in_ready/in_r/g/b: signed per-channel conv results, accepted only while filling
// out_valid/out_ready/out_r/g/b/out_row/out_col/out_last: clamped pixels with raster tags
// sat_flag: sticky, set if any channel of the current frame saturated
module conv_result_collector #(
  parameter int OUT_W = conv_pkg::OUT_W,
  parameter int MAP_W = conv_pkg::MAP_W,
  parameter int MAP_H = conv_pkg::MAP_H,
  parameter int CLAMP_EN = 1
) (
  input  logic                                sys_clk,
  input  logic                                sys_rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [OUT_W-1:0]                    in_r,
  input  logic [OUT_W-1:0]                    in_g,
  input  logic [OUT_W-1:0]                    in_b,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [7:0]                          out_r,
  output logic [7:0]                          out_g,
  output logic [7:0]                          out_b,
  output logic [conv_pkg::idx_w(MAP_H)-1:0]   out_row,
  output logic [conv_pkg::idx_w(MAP_W)-1:0]   out_col,
  output logic                                out_last,
  output logic                                sat_flag
);
  import conv_pkg::*;
  localparam int N = MAP_W * MAP_H;
  localparam int IW = idx_w(N);
  localparam int RW = idx_w(MAP_H);
  localparam int CW = idx_w(MAP_W);
  state_t state;
  logic [IW-1:0] wr_idx, rd_idx, nxt_idx;
  logic [23:0] buf_mem [N];
  logic [7:0] cr, cg, cb;
  logic sr, sg, sb, in_hs, out_hs, last_wr, ld;
  pix_clamp #(.IN_W(OUT_W), .CLAMP_EN(CLAMP_EN)) u_clamp_r (.value(in_r), .pix(cr), .sat(sr));
  pix_clamp #(.IN_W(OUT_W), .CLAMP_EN(CLAMP_EN)) u_clamp_g (.value(in_g), .pix(cg), .sat(sg));
  pix_clamp #(.IN_W(OUT_W), .CLAMP_EN(CLAMP_EN)) u_clamp_b (.value(in_b), .pix(cb), .sat(sb));
  assign in_ready = state == FILL;
  assign in_hs = in_valid && in_ready;
  assign out_hs = out_valid && out_ready;
  assign last_wr = wr_idx == IW'(N - 1);
  // pixel 0 is preloaded on the final write so out_valid rises with no bubble
  assign nxt_idx = state == FILL ? '0 : rd_idx + 1'b1;
  assign ld = state == FILL ? in_hs && last_wr : out_hs && !out_last;
  always_ff @(posedge sys_clk)
    if (in_hs) buf_mem[wr_idx] <= {cr, cg, cb};
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state <= FILL;
      wr_idx <= '0;
      rd_idx <= '0;
      out_valid <= 1'b0;
      {out_r, out_g, out_b} <= '0;
      out_row <= '0;
      out_col <= '0;
      out_last <= 1'b0;
      sat_flag <= 1'b0;
    end else begin
      if (state == FILL && in_hs) begin
        sat_flag <= sat_flag | sr | sg | sb;
        wr_idx <= last_wr ? '0 : wr_idx + 1'b1;
        if (last_wr) state <= DRAIN;
        if (last_wr) out_valid <= 1'b1;
      end
      if (state == DRAIN && out_hs && out_last) begin
        state <= FILL;
        out_valid <= 1'b0;
        out_last <= 1'b0;
        rd_idx <= '0;
        sat_flag <= 1'b0;
      end
      if (ld) begin
        rd_idx <= nxt_idx;
        {out_r, out_g, out_b} <= buf_mem[nxt_idx];
        out_row <= RW'(nxt_idx / IW'(MAP_W));
        out_col <= CW'(nxt_idx % IW'(MAP_W));
        out_last <= nxt_idx == IW'(N - 1);
      end
    end
  end
endmodule

// File: tb/tb_conv_result_collector.sv
// tb_conv_result_collector: randomized self-checking bench for saturating and wrapping collector variants
module tb_conv_result_collector;
  logic sys_clk = 1'b0, sys_rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic [15:0] in_r = '0, in_g = '0, in_b = '0;
  logic in_ready, out_valid, out_last, sat_flag;
  logic [7:0] out_r, out_g, out_b;
  logic [1:0] out_row, out_col;
  logic in_ready_w, out_valid_w, out_last_w, sat_flag_w;
  logic [7:0] out_r_w, out_g_w, out_b_w;
  logic [1:0] out_row_w, out_col_w;
  int vectors = 0, miscompares = 0;
  int fr_r [16], fr_g [16], fr_b [16];
  always #5 sys_clk = ~sys_clk;
  conv_result_collector #(.CLAMP_EN(1)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_r(in_r), .in_g(in_g), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_r(out_r), .out_g(out_g), .out_b(out_b), .out_row(out_row), .out_col(out_col),
    .out_last(out_last), .sat_flag(sat_flag));
  conv_result_collector #(.CLAMP_EN(0)) dut_w (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .in_valid(in_valid), .in_ready(in_ready_w),
    .in_r(in_r), .in_g(in_g), .in_b(in_b), .out_valid(out_valid_w), .out_ready(out_ready),
    .out_r(out_r_w), .out_g(out_g_w), .out_b(out_b_w), .out_row(out_row_w), .out_col(out_col_w),
    .out_last(out_last_w), .sat_flag(sat_flag_w));
  function automatic int clampf(input int v);
    return v < 0 ? 0 : v > 255 ? 255 : v;
  endfunction
  function automatic int wrapf(input int v);
    return v & 255;
  endfunction
  function automatic bit frame_sat();
    bit s = 0;
    for (int i = 0; i < 16; i++)
      s |= (clampf(fr_r[i]) != fr_r[i]) || (clampf(fr_g[i]) != fr_g[i]) || (clampf(fr_b[i]) != fr_b[i]);
    return s;
  endfunction
  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask
  task automatic gen(input int lo, input int hi);
    for (int i = 0; i < 16; i++) begin
      fr_r[i] = lo + int'($urandom_range(0, hi - lo));
      fr_g[i] = lo + int'($urandom_range(0, hi - lo));
      fr_b[i] = lo + int'($urandom_range(0, hi - lo));
    end
  endtask
  task automatic basic_frame();
    for (int i = 0; i < 16; i++) begin
      fr_r[i] = i;
      fr_g[i] = 100 + i;
      fr_b[i] = 200 + i;
    end
  endtask
  task automatic fill(input bit gap);
    int n = 0, cyc = 0;
    bit hs;
    while (n < 16 && cyc < 400) begin
      in_valid = gap ? (cyc % 3 == 0) : 1'b1;
      in_r = in_valid ? fr_r[n][15:0] : 16'($urandom);
      in_g = in_valid ? fr_g[n][15:0] : 16'($urandom);
      in_b = in_valid ? fr_b[n][15:0] : 16'($urandom);
      vectors++;
      if ({in_ready, out_valid} !== 2'b10) begin
        miscompares++;
        $display("FAIL fill_idle n=%0d in_ready/out_valid=%b%b required 10", n, in_ready, out_valid);
      end
      hs = in_valid;
      step();
      cyc++;
      if (hs) n++;
    end
    in_valid = 1'b0;
    vectors++;
    if (n != 16) begin
      miscompares++;
      $display("FAIL fill_budget accepted=%0d required 16", n);
    end
  endtask
  task automatic drain(input bit rnd, input int stop, input bit sat_exp);
    int k = 0, cyc = 0;
    bit hs;
    while (k < stop && cyc < 400) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      in_valid = 1'b1;
      in_r = 16'($urandom);
      in_g = 16'($urandom);
      in_b = 16'($urandom);
      vectors++;
      if ({out_valid, in_ready, out_r, out_g, out_b, out_row, out_col, out_last, sat_flag} !==
          {1'b1, 1'b0, 8'(clampf(fr_r[k])), 8'(clampf(fr_g[k])), 8'(clampf(fr_b[k])),
           2'(k / 4), 2'(k % 4), (k == 15), sat_exp}) begin
        miscompares++;
        $display("FAIL drain_sat k=%0d got v=%b rdy=%b rgb=%0d,%0d,%0d row=%0d col=%0d last=%b sat=%b required rgb=%0d,%0d,%0d row=%0d col=%0d last=%b sat=%b",
                 k, out_valid, in_ready, out_r, out_g, out_b, out_row, out_col, out_last, sat_flag,
                 clampf(fr_r[k]), clampf(fr_g[k]), clampf(fr_b[k]), k / 4, k % 4, k == 15, sat_exp);
      end
      vectors++;
      if ({out_valid_w, in_ready_w, out_r_w, out_g_w, out_b_w, out_row_w, out_col_w, out_last_w, sat_flag_w} !==
          {1'b1, 1'b0, 8'(wrapf(fr_r[k])), 8'(wrapf(fr_g[k])), 8'(wrapf(fr_b[k])),
           2'(k / 4), 2'(k % 4), (k == 15), 1'b0}) begin
        miscompares++;
        $display("FAIL drain_wrap k=%0d got v=%b rgb=%0d,%0d,%0d last=%b sat=%b required rgb=%0d,%0d,%0d last=%b sat=0",
                 k, out_valid_w, out_r_w, out_g_w, out_b_w, out_last_w, sat_flag_w,
                 wrapf(fr_r[k]), wrapf(fr_g[k]), wrapf(fr_b[k]), k == 15);
      end
      hs = out_ready;
      step();
      cyc++;
      if (hs) k++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    vectors++;
    if (k != stop) begin
      miscompares++;
      $display("FAIL drain_budget drained=%0d required %0d", k, stop);
    end
    if (stop == 16) begin
      vectors++;
      if ({out_valid, in_ready, sat_flag, out_valid_w, in_ready_w} !== 5'b01001) begin
        miscompares++;
        $display("FAIL drain_end v/rdy/sat/v_w/rdy_w=%b%b%b%b%b required 01001",
                 out_valid, in_ready, sat_flag, out_valid_w, in_ready_w);
      end
    end
  endtask
  task automatic test_reset();
    sys_rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    step();
    step();
    sys_rst = 1'b0;
    vectors++;
    if ({in_ready, out_valid, sat_flag, out_r, out_g, out_b, out_row, out_col, out_last} !== {3'b100, 29'd0} ||
        {in_ready_w, out_valid_w, sat_flag_w, out_r_w, out_g_w, out_b_w, out_row_w, out_col_w, out_last_w} !== {3'b100, 29'd0}) begin
      miscompares++;
      $display("FAIL reset_state rdy=%b v=%b sat=%b rgb=%0d,%0d,%0d row=%0d col=%0d last=%b required rdy=1 rest 0",
               in_ready, out_valid, sat_flag, out_r, out_g, out_b, out_row, out_col, out_last);
    end
  endtask
  task automatic test_basic();
    basic_frame();
    fill(1'b0);
    drain(1'b0, 16, frame_sat());
  endtask
  task automatic test_clamp();
    gen(-400, 700);
    fr_r[0] = -6;
    fr_g[0] = 300;
    fr_b[0] = 128;
    fill(1'b0);
    drain(1'b0, 16, frame_sat());
  endtask
  task automatic test_backpressure();
    for (int f = 0; f < 3; f++) begin
      gen(f == 0 ? 0 : -300, f == 0 ? 255 : 600);
      fill(1'b0);
      drain(1'b1, 16, frame_sat());
    end
  endtask
  task automatic test_gaps();
    basic_frame();
    fill(1'b1);
    drain(1'b0, 16, frame_sat());
    gen(-200, 500);
    fill(1'b1);
    drain(1'b1, 16, frame_sat());
  endtask
  task automatic test_mid_reset();
    gen(-300, 600);
    fr_g[2] = 999;
    fill(1'b0);
    drain(1'b0, 5, frame_sat());
    sys_rst = 1'b1;
    step();
    sys_rst = 1'b0;
    vectors++;
    if ({in_ready, out_valid, sat_flag, out_r, out_g, out_b, out_row, out_col, out_last} !== {3'b100, 29'd0}) begin
      miscompares++;
      $display("FAIL mid_reset rdy=%b v=%b sat=%b rgb=%0d,%0d,%0d row=%0d col=%0d last=%b required rdy=1 rest 0",
               in_ready, out_valid, sat_flag, out_r, out_g, out_b, out_row, out_col, out_last);
    end
    gen(0, 255);
    fill(1'b0);
    drain(1'b0, 16, frame_sat());
  endtask
  initial begin
    test_reset();
    test_basic();
    test_clamp();
    test_backpressure();
    test_gaps();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
